// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard scoreboard bus: instruction fields from the ID stage,
// pipeline control, long-latency writeback strobe, and scoreboard status.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int LAT_W      = 3
);
  logic                     id_valid;
  logic [REG_ADDR_W-1:0]    id_src1;
  logic [REG_ADDR_W-1:0]    id_src2;
  logic                     id_two_regs;
  logic [REG_ADDR_W-1:0]    id_dest;
  logic                     id_wb_en;
  logic [LAT_W-1:0]         id_lat;
  logic                     en_fwd;
  logic                     freeze;
  logic                     flush;
  logic                     wb_done;
  logic [REG_ADDR_W-1:0]    wb_dest;
  logic                     hazard_detected;
  logic [2**REG_ADDR_W-1:0] busy_vec;
  logic [REG_ADDR_W:0]      pend_count;

  // Pipeline side: drives instruction/control, observes the stall.
  modport master (
    output id_valid, id_src1, id_src2, id_two_regs, id_dest, id_wb_en, id_lat,
    output en_fwd, freeze, flush, wb_done, wb_dest,
    input  hazard_detected, busy_vec, pend_count
  );

  // Scoreboard side.
  modport slave (
    input  id_valid, id_src1, id_src2, id_two_regs, id_dest, id_wb_en, id_lat,
    input  en_fwd, freeze, flush, wb_done, wb_dest,
    output hazard_detected, busy_vec, pend_count
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write scoreboard for the ID stage. Each destination
// register carries a busy bit and a countdown; the all-ones count marks a
// long-latency producer that only clears on an explicit writeback strobe.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int LAT_W      = 3,
  parameter int WB_DIST    = 3
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave bus
);
  localparam int NREG = 2**REG_ADDR_W;
  localparam logic [LAT_W-1:0] LONG_LAT  = '1;
  localparam logic [LAT_W-1:0] WB_DIST_C = LAT_W'(WB_DIST);

  logic [NREG-1:0]     busy_w;          // current busy bits
  logic [NREG-1:0]     busy_nx;         // next-state busy bits
  logic [NREG-1:0]     long_w;          // busy with long-latency code
  logic [REG_ADDR_W:0] pend_reg, pend_next;

  logic            raw, waw, hazard, issue_wr;
  logic [LAT_W-1:0] load_val;

  // Stall decision and the countdown value a new producer would start with.
  always_comb begin
    raw = (busy_w[bus.id_src1] && bus.id_src1 != '0) ||
          (bus.id_two_regs && busy_w[bus.id_src2] && bus.id_src2 != '0);
    waw = bus.id_wb_en && bus.id_dest != '0 && long_w[bus.id_dest];
    hazard   = bus.id_valid && !bus.flush && (raw || waw);
    issue_wr = bus.id_valid && !bus.flush && !bus.freeze && !hazard &&
               bus.id_wb_en && bus.id_dest != '0;
    if (bus.en_fwd)
      load_val = bus.id_lat;
    else if (bus.id_lat == LONG_LAT)
      load_val = LONG_LAT;
    else
      load_val = WB_DIST_C;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_entry
      logic             busy_reg, busy_next;
      logic [LAT_W-1:0] cnt_reg, cnt_next;
      logic             dest_hit, wb_hit;

      assign dest_hit = issue_wr && (bus.id_dest == REG_ADDR_W'(gi));
      assign wb_hit   = bus.wb_done && (bus.wb_dest == REG_ADDR_W'(gi)) &&
                        busy_reg && (cnt_reg == LONG_LAT);

      // Entry update priority: new issue, then long writeback, then countdown.
      // An issue with a zero load leaves no entry: the value forwards at once.
      always_comb begin
        busy_next = busy_reg;
        cnt_next  = cnt_reg;
        if (dest_hit) begin
          busy_next = (load_val != '0);
          cnt_next  = load_val;
        end else if (wb_hit) begin
          busy_next = 1'b0;
          cnt_next  = '0;
        end else if (!bus.freeze && busy_reg && cnt_reg != LONG_LAT) begin
          if (cnt_reg == LAT_W'(1)) begin
            busy_next = 1'b0;
            cnt_next  = '0;
          end else begin
            cnt_next = cnt_reg - LAT_W'(1);
          end
        end
      end

      // Entry state register; reset drops every pending write.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          busy_reg <= 1'b0;
          cnt_reg  <= '0;
        end else begin
          busy_reg <= busy_next;
          cnt_reg  <= cnt_next;
        end
      end

      assign busy_w[gi]  = busy_reg;
      assign busy_nx[gi] = busy_next;
      assign long_w[gi]  = busy_reg && (cnt_reg == LONG_LAT);
    end
  endgenerate

  // Population count of the next busy vector so the count tracks busy_vec.
  always_comb begin
    pend_next = '0;
    for (int i = 0; i < NREG; i++)
      pend_next = pend_next + (REG_ADDR_W+1)'(busy_nx[i]);
  end

  // Registered pending-entry count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_reg <= '0;
    else     pend_reg <= pend_next;
  end

  assign bus.hazard_detected = hazard;
  assign bus.busy_vec        = busy_w;
  assign bus.pend_count      = pend_reg;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding chain, load-use,
// no-forward distance, long latency with WAW, freeze/flush, r0, reset.
module tb_hazard_scoreboard;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  hazard_scoreboard_if #(.REG_ADDR_W(5), .LAT_W(3)) hif ();

  hazard_scoreboard #(.REG_ADDR_W(5), .LAT_W(3), .WB_DIST(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic id_set(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                        input logic two, input logic [4:0] d, input logic we,
                        input logic [2:0] lat);
    hif.id_valid    = v;
    hif.id_src1     = s1;
    hif.id_src2     = s2;
    hif.id_two_regs = two;
    hif.id_dest     = d;
    hif.id_wb_en    = we;
    hif.id_lat      = lat;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    id_set(0, 0, 0, 0, 0, 0, 0);
    hif.en_fwd = 1'b1; hif.freeze = 1'b0; hif.flush = 1'b0;
    hif.wb_done = 1'b0; hif.wb_dest = '0;
    #1;
    chk("rst_hazard", 64'(hif.hazard_detected), 64'd0);
    chk("rst_busy", 64'(hif.busy_vec), 64'd0);
    chk("rst_pend", 64'(hif.pend_count), 64'd0);
    nxt(); nxt();
    rst = 1'b0;

    // Forwarding ALU chain: lat=0 creates no entry.
    nxt(); id_set(1, 1, 2, 1, 3, 1, 0); #1;
    chk("alu_issue_hz", 64'(hif.hazard_detected), 64'd0);
    nxt(); id_set(1, 3, 0, 0, 0, 0, 0); #1;
    chk("alu_use_hz", 64'(hif.hazard_detected), 64'd0);
    chk("alu_pend", 64'(hif.pend_count), 64'd0);
    chk("alu_busy", 64'(hif.busy_vec), 64'd0);

    // Load-use: one stall cycle.
    nxt(); id_set(1, 1, 2, 0, 4, 1, 1); #1;
    nxt(); id_set(1, 4, 0, 0, 0, 0, 0); #1;
    chk("ld_use_hz1", 64'(hif.hazard_detected), 64'd1);
    chk("ld_busy", 64'(hif.busy_vec), 64'h10);
    chk("ld_pend", 64'(hif.pend_count), 64'd1);
    nxt(); #1;
    chk("ld_use_hz2", 64'(hif.hazard_detected), 64'd0);
    chk("ld_busy_clr", 64'(hif.busy_vec), 64'd0);
    chk("ld_pend_clr", 64'(hif.pend_count), 64'd0);

    // No forwarding: WB_DIST=3 stall cycles.
    nxt(); hif.en_fwd = 1'b0; id_set(1, 1, 2, 0, 5, 1, 0); #1;
    nxt(); id_set(1, 1, 5, 1, 0, 0, 0); #1;
    chk("nofwd_hz1", 64'(hif.hazard_detected), 64'd1);
    chk("nofwd_pend", 64'(hif.pend_count), 64'd1);
    nxt(); #1; chk("nofwd_hz2", 64'(hif.hazard_detected), 64'd1);
    nxt(); #1; chk("nofwd_hz3", 64'(hif.hazard_detected), 64'd1);
    nxt(); #1; chk("nofwd_hz4", 64'(hif.hazard_detected), 64'd0);
    chk("nofwd_busy", 64'(hif.busy_vec), 64'd0);

    // Long divide on r6: indefinite stall, WAW stall, wb_done clears.
    nxt(); hif.en_fwd = 1'b1; id_set(1, 1, 2, 0, 6, 1, 7); #1;
    nxt(); id_set(1, 6, 0, 0, 0, 0, 0); #1;
    chk("long_hz_a", 64'(hif.hazard_detected), 64'd1);
    for (int i = 0; i < 6; i++) nxt();
    #1;
    chk("long_hz_b", 64'(hif.hazard_detected), 64'd1);
    chk("long_busy", 64'(hif.busy_vec), 64'h40);
    id_set(1, 1, 0, 0, 6, 1, 0); #1;
    chk("waw_hz", 64'(hif.hazard_detected), 64'd1);
    hif.wb_done = 1'b1; hif.wb_dest = 5'd9;
    nxt(); hif.wb_done = 1'b0; #1;
    chk("wb_idle_busy", 64'(hif.busy_vec), 64'h40);
    chk("wb_idle_pend", 64'(hif.pend_count), 64'd1);
    hif.wb_done = 1'b1; hif.wb_dest = 5'd6;
    nxt(); hif.wb_done = 1'b0; #1;
    chk("wb_busy_clr", 64'(hif.busy_vec), 64'd0);
    chk("wb_pend_clr", 64'(hif.pend_count), 64'd0);
    chk("waw_hz_drop", 64'(hif.hazard_detected), 64'd0);
    id_set(0, 0, 0, 0, 0, 0, 0);

    // Freeze holds r7's count; flush masks the hazard and blocks issue.
    nxt(); id_set(1, 1, 2, 0, 7, 1, 2); #1;
    nxt(); id_set(0, 0, 0, 0, 0, 0, 0); hif.freeze = 1'b1;
    for (int i = 0; i < 4; i++) nxt();
    #1;
    chk("frz_busy", 64'(hif.busy_vec), 64'h80);
    hif.freeze = 1'b0;
    id_set(1, 7, 0, 0, 10, 1, 3); hif.flush = 1'b1; #1;
    chk("flush_hz", 64'(hif.hazard_detected), 64'd0);
    nxt(); hif.flush = 1'b0; #1;
    chk("flush_noissue", 64'(hif.busy_vec), 64'h80);
    chk("frz_use_hz", 64'(hif.hazard_detected), 64'd1);
    nxt(); #1;
    chk("frz_clr_busy", 64'(hif.busy_vec), 64'd0);
    chk("frz_clr_hz", 64'(hif.hazard_detected), 64'd0);
    id_set(0, 0, 0, 0, 0, 0, 0);

    // r0 as sources and destination.
    nxt(); id_set(1, 0, 0, 1, 0, 1, 5); #1;
    chk("r0_hz_a", 64'(hif.hazard_detected), 64'd0);
    nxt(); #1;
    chk("r0_hz_b", 64'(hif.hazard_detected), 64'd0);
    chk("r0_busy", 64'(hif.busy_vec), 64'd0);
    chk("r0_pend", 64'(hif.pend_count), 64'd0);

    // wb_done honoured while frozen.
    nxt(); id_set(1, 1, 0, 0, 11, 1, 7); #1;
    nxt(); id_set(0, 0, 0, 0, 0, 0, 0); hif.freeze = 1'b1;
    hif.wb_done = 1'b1; hif.wb_dest = 5'd11; #1;
    chk("frzwb_busy", 64'(hif.busy_vec), 64'h800);
    nxt(); hif.wb_done = 1'b0; hif.freeze = 1'b0; #1;
    chk("frzwb_clr", 64'(hif.busy_vec), 64'd0);

    // Reset mid-operation with r2 long and r8 counting.
    nxt(); id_set(1, 1, 0, 0, 2, 1, 7); #1;
    nxt(); id_set(1, 1, 0, 0, 8, 1, 2); #1;
    nxt(); id_set(1, 1, 0, 0, 8, 1, 1); #1;
    chk("pre_rst_pend", 64'(hif.pend_count), 64'd2);
    chk("pre_rst_busy", 64'(hif.busy_vec), 64'h104);
    chk("waw_short_hz", 64'(hif.hazard_detected), 64'd0);
    hif.id_src1 = 5'd2; #1;
    chk("pre_rst_raw", 64'(hif.hazard_detected), 64'd1);
    #1; rst = 1'b1; #1;
    chk("mid_rst_busy", 64'(hif.busy_vec), 64'd0);
    chk("mid_rst_pend", 64'(hif.pend_count), 64'd0);
    chk("mid_rst_hz", 64'(hif.hazard_detected), 64'd0);
    nxt(); rst = 1'b0; #1;
    chk("post_rst_hz", 64'(hif.hazard_detected), 64'd0);
    id_set(0, 0, 0, 0, 0, 0, 0);
    nxt(); nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
